// File: rtl/fifo_stream_pkg.sv
// Shared constants, types and helpers for the FIFO stream reader.
package fifo_stream_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    int unsigned rem;
    bits = 0;
    rem  = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying data plus an end-of-burst marker.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order buffer; head is slot0, push writes the first free slot.
module stream_skid_buf2
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output occ_t                  count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  occ_t                  count_q, count_d;
  logic                  pop_eff;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    pop_eff = pop && (count_q != occ_t'(0));
    case ({push, pop_eff})
      2'b10: begin
        if (count_q == occ_t'(0)) slot0_d = din;
        else                      slot1_d = din;
        count_d = occ_t'(count_q + occ_t'(1));
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = occ_t'(count_q - occ_t'(1));
      end
      // Simultaneous push/pop: head advances, new word lands behind it.
      2'b11: begin
        if (count_q == occ_t'(1)) begin
          slot0_d = din;
        end else begin
          slot0_d = slot1_q;
          slot1_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= occ_t'(SKID_DEPTH))
    else $error("skid buffer count exceeds depth");
  a_no_full_push: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_eff && (count_q == occ_t'(SKID_DEPTH))))
    else $error("capture into full skid buffer");
`endif

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a latency-1 FIFO into a valid/ready stream framed into fixed-length bursts.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  fifo_stream_reader_if.master       m_if,
  output logic                       burst_done,
  output logic [CNT_WIDTH-1:0]       burst_cnt
);

  localparam int unsigned          BEAT_BITS = clog2(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  if (BEAT_BITS > CNT_WIDTH) begin : g_cnt_too_narrow
    $error("CNT_WIDTH too narrow for BURST_LEN");
  end

  occ_t                  count;
  logic [DATA_WIDTH-1:0] head;
  logic                  valid;
  logic                  last;
  logic                  pop;
  logic                  room;
  logic                  rd_en;

  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic                  burst_done_q, burst_done_d;
  logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

  stream_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (fifo_dout),
    .count (count),
    .head  (head)
  );

  // Issue a read only when the word is guaranteed a slot on arrival.
  always_comb begin
    valid        = (count != occ_t'(0));
    last         = valid && (beat_q == LAST_BEAT);
    pop          = valid && m_if.m_ready;
    room         = (3'(count) + 3'(inflight_q)) < (3'(SKID_DEPTH) + 3'(pop));
    rd_en        = !fifo_empty && room && !rst;
    inflight_d   = rd_en;
    beat_d       = beat_q;
    if (pop) begin
      beat_d = last ? '0 : CNT_WIDTH'(beat_q + CNT_WIDTH'(1));
    end
    burst_done_d = pop && last;
    burst_cnt_d  = CNT_WIDTH'(burst_cnt_q + CNT_WIDTH'(burst_done_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q   <= 1'b0;
      beat_q       <= '0;
      burst_done_q <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      inflight_q   <= inflight_d;
      beat_q       <= beat_d;
      burst_done_q <= burst_done_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign fifo_rd_en   = rd_en;
  assign m_if.m_data  = head;
  assign m_if.m_valid = valid;
  assign m_if.m_last  = last;
  assign burst_done   = burst_done_q;
  assign burst_cnt    = burst_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a BURST_LEN=16 instance and a BURST_LEN=1 instance.
module tb_fifo_stream_reader;

  localparam int unsigned DW     = 32;
  localparam int unsigned CW     = 16;
  localparam int unsigned FDEPTH = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) if_a ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW)) if_b ();

  logic [DW-1:0] f_dout [2];
  logic          f_empty[2];
  logic          f_rd   [2];
  logic          done   [2];
  logic [CW-1:0] bcnt   [2];

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(16), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .rst(rst), .fifo_dout(f_dout[0]), .fifo_empty(f_empty[0]),
    .fifo_rd_en(f_rd[0]), .m_if(if_a), .burst_done(done[0]), .burst_cnt(bcnt[0]));

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst(rst), .fifo_dout(f_dout[1]), .fifo_empty(f_empty[1]),
    .fifo_rd_en(f_rd[1]), .m_if(if_b), .burst_done(done[1]), .burst_cnt(bcnt[1]));

  logic [DW-1:0] s_data[2];
  logic s_valid[2], s_ready[2], s_last[2];
  assign s_data[0] = if_a.m_data;  assign s_data[1] = if_b.m_data;
  assign s_valid[0] = if_a.m_valid; assign s_valid[1] = if_b.m_valid;
  assign s_ready[0] = if_a.m_ready; assign s_ready[1] = if_b.m_ready;
  assign s_last[0] = if_a.m_last;  assign s_last[1] = if_b.m_last;

  // Behavioural latency-1 FIFOs; flushed on the first edge of a reset.
  logic [DW-1:0] fmem[2][0:FDEPTH-1];
  int fwr[2] = '{0, 0};
  int frd[2] = '{0, 0};
  assign f_empty[0] = (fwr[0] == frd[0]);
  assign f_empty[1] = (fwr[1] == frd[1]);

  always @(posedge clk) begin
    rst_d <= rst;
    for (int i = 0; i < 2; i++) begin
      if (rst && !rst_d) frd[i] <= fwr[i];
      else if (f_rd[i]) begin
        f_dout[i] <= fmem[i][frd[i]];
        frd[i]    <= frd[i] + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state: stream order is FIFO order, framing from beat count.
  int hs[2], reads[2], bursts[2], exp_ptr[2], done_seen[2], bl[2];
  bit exp_done[2], prev_stall[2], prev_last[2];
  logic [DW-1:0] prev_data[2];
  bit rst_prev = 1'b0;

  typedef struct {
    logic          ready;
    logic          rd_en;
    logic          valid;
    logic [DW-1:0] data;
  } vec_t;
  vec_t lat_tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [DW-1:0] w);
    fmem[i][fwr[i]] = w;
    fwr[i]++;
  endtask

  task automatic mon_cycle(input int i);
    bit pop;
    bit last_exp;
    if (rst) begin
      if (rst_prev) begin
        chk($sformatf("rst_valid%0d", i), s_valid[i], 0);
        chk($sformatf("rst_last%0d", i), s_last[i], 0);
        chk($sformatf("rst_data%0d", i), s_data[i], 0);
        chk($sformatf("rst_done%0d", i), done[i], 0);
        chk($sformatf("rst_bcnt%0d", i), bcnt[i], 0);
      end
      chk($sformatf("rst_rd_en%0d", i), f_rd[i], 0);
      hs[i] = 0; reads[i] = 0; bursts[i] = 0; done_seen[i] = 0;
      exp_done[i] = 0; prev_stall[i] = 0; exp_ptr[i] = frd[i];
    end else begin
      last_exp = (hs[i] % bl[i]) == (bl[i] - 1);
      pop = s_valid[i] && s_ready[i];
      chk($sformatf("burst_done%0d", i), done[i], exp_done[i]);
      chk($sformatf("burst_cnt%0d", i), bcnt[i], 64'(bursts[i] & 32'hFFFF));
      if (prev_stall[i]) begin
        chk($sformatf("stall_valid%0d", i), s_valid[i], 1);
        chk($sformatf("stall_data%0d", i), s_data[i], prev_data[i]);
        chk($sformatf("stall_last%0d", i), s_last[i], prev_last[i]);
      end
      if (s_valid[i]) begin
        if (exp_ptr[i] < fwr[i]) chk($sformatf("data%0d", i), s_data[i], fmem[i][exp_ptr[i]]);
        else chk($sformatf("unexpected_beat%0d", i), s_valid[i], 0);
        chk($sformatf("last%0d", i), s_last[i], last_exp);
      end
      if (f_rd[i]) reads[i]++;
      chk($sformatf("occupancy%0d", i), (reads[i] - hs[i] - int'(pop)) <= 2, 1);
      exp_done[i] = pop && last_exp;
      if (pop) begin
        hs[i]++;
        exp_ptr[i]++;
        if (last_exp) bursts[i]++;
      end
      if (done[i]) done_seen[i]++;
      prev_stall[i] = s_valid[i] && !s_ready[i];
      prev_data[i]  = s_data[i];
      prev_last[i]  = s_last[i];
    end
  endtask

  task automatic wait_hs(input int i, input int n, input int budget, input string name);
    int k = 0;
    while (hs[i] < n && k < budget) begin step(); k++; end
    chk(name, hs[i] >= n, 1);
  endtask

  task automatic wait_valid(input int i, input int budget, input string name);
    int k = 0;
    while (!s_valid[i] && k < budget) begin step(); k++; end
    chk(name, s_valid[i], 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bl[0] = 16;
    bl[1] = 1;
    // Cycle-by-cycle view right after reset release, FIFO holding A0..A3.
    lat_tbl[0] = '{ready: 0, rd_en: 1, valid: 0, data: 32'h0};
    lat_tbl[1] = '{ready: 0, rd_en: 1, valid: 0, data: 32'h0};
    lat_tbl[2] = '{ready: 0, rd_en: 0, valid: 1, data: 32'hA0};
    lat_tbl[3] = '{ready: 0, rd_en: 0, valid: 1, data: 32'hA0};
    lat_tbl[4] = '{ready: 1, rd_en: 1, valid: 1, data: 32'hA0};
    lat_tbl[5] = '{ready: 1, rd_en: 1, valid: 1, data: 32'hA1};
    lat_tbl[6] = '{ready: 1, rd_en: 0, valid: 1, data: 32'hA2};
    lat_tbl[7] = '{ready: 1, rd_en: 0, valid: 1, data: 32'hA3};
    lat_tbl[8] = '{ready: 1, rd_en: 0, valid: 0, data: 32'h0};
    if_a.m_ready = 1'b0;
    if_b.m_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon_cycle(0);
        mon_cycle(1);
        rst_prev = rst;
      end
    join_none

    // Reset held 3 edges with a non-empty FIFO.
    step();
    for (int k = 0; k < 4; k++) push(0, DW'(32'hA0 + k));
    chk("hold_rst_rd_en", f_rd[0], 0);
    step();
    chk("hold_rst_rd_en", f_rd[0], 0);
    chk("hold_rst_valid", s_valid[0], 0);
    chk("hold_rst_bcnt", bcnt[0], 0);
    step();
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      if_a.m_ready = lat_tbl[k].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_en", k), f_rd[0], lat_tbl[k].rd_en);
      chk($sformatf("tbl%0d_valid", k), s_valid[0], lat_tbl[k].valid);
      if (lat_tbl[k].valid) chk($sformatf("tbl%0d_data", k), s_data[0], lat_tbl[k].data);
      step();
    end

    // Streaming: 32 back-to-back beats, two bursts.
    if_a.m_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 32; k++) push(0, DW'(k));
    wait_valid(0, 10, "stream_start");
    for (int k = 0; k < 32; k++) begin
      chk("stream_gap", s_valid[0], 1);
      step();
    end
    chk("stream_beats", 64'(hs[0]), 32);
    chk("stream_bcnt", bcnt[0], 2);
    step();
    chk("stream_done_pulses", 64'(done_seen[0]), 2);

    // Back-pressure mid-stream.
    for (int k = 0; k < 20; k++) push(0, DW'(100 + k));
    wait_hs(0, 37, 20, "bp_reach");
    if_a.m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k >= 2) begin
        chk("bp_rd_en", f_rd[0], 0);
        chk("bp_buffered", 64'(reads[0] - hs[0]), 2);
        chk("bp_valid", s_valid[0], 1);
      end
    end
    if_a.m_ready = 1'b1;
    wait_hs(0, 52, 40, "bp_drain");
    chk("bp_all_words", 64'(exp_ptr[0]), 64'(fwr[0]));

    // Starvation after beat 5, refill 7 cycles later.
    do_reset();
    for (int k = 0; k < 6; k++) push(0, DW'(200 + k));
    wait_hs(0, 6, 20, "starve_first");
    step();
    step();
    for (int k = 0; k < 7; k++) begin
      chk("starve_gap", s_valid[0], 0);
      step();
    end
    for (int k = 0; k < 10; k++) push(0, DW'(206 + k));
    wait_valid(0, 10, "starve_resume");
    chk("starve_resume_data", s_data[0], 206);
    chk("starve_resume_last", s_last[0], 0);
    wait_hs(0, 16, 30, "starve_finish");
    chk("starve_bcnt", bcnt[0], 1);
    step();
    chk("starve_done_pulses", 64'(done_seen[0]), 1);

    // Reset at beat 9 with two words buffered.
    do_reset();
    for (int k = 0; k < 20; k++) push(0, DW'(300 + k));
    wait_hs(0, 9, 20, "mid_reach");
    if_a.m_ready = 1'b0;
    step(); step(); step();
    chk("mid_buffered", 64'(reads[0] - hs[0]), 2);
    chk("mid_valid_before", s_valid[0], 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", s_valid[0], 0);
    chk("mid_rst_rd_en", f_rd[0], 0);
    step();
    rst = 1'b0;
    if_a.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(0, DW'(400 + k));
    wait_valid(0, 10, "mid_restart");
    chk("mid_first_data", s_data[0], 400);
    chk("mid_first_last", s_last[0], 0);

    // Random back-pressure, BURST_LEN=1, 1000 words.
    if_a.m_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 1000; k++) push(1, DW'($urandom));
    begin
      int k = 0;
      while (hs[1] < 1000 && k < 8000) begin
        if_b.m_ready = 1'($urandom_range(0, 1));
        step();
        k++;
      end
    end
    chk("rand_beats", 64'(hs[1]), 1000);
    if_b.m_ready = 1'b0;
    step();
    chk("rand_bcnt", bcnt[1], 64'(1000 % 65536));
    chk("rand_done_pulses", 64'(done_seen[1]), 1000);
    chk("rand_all_words", 64'(exp_ptr[1]), 64'(fwr[1]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
